// File: rtl/sar_multiphase_clock_gen.sv
`default_nettype none
// ============================================================================
// Module   : sar_multiphase_clock_gen
// Purpose  : NCH-phase, non-overlapping round-robin sample clocks with
//            per-channel conversion strobes and frame sync for an interleaved SAR.
// Revision : 1.0
// ============================================================================
module sar_multiphase_clock_gen #(
  parameter int NCH        = 4,
  parameter int CNT_W      = 8,
  parameter int DEF_PERIOD = 10,
  parameter int DEF_HIGH   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] high_cyc,
  output logic [NCH-1:0]   clk_samp,
  output logic [NCH-1:0]   conv_start,
  output logic             frame_sync,
  output logic             cfg_err
);

  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CH_W-1:0] C_LAST_CH = CH_W'(NCH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic [CNT_W-1:0] hi_q, hi_d;
  logic             err_d;
  logic [NCH-1:0]   samp_d, conv_d;
  logic             fs_d;

  logic [CNT_W-1:0] eff_per, eff_hi;
  logic             eff_err;
  logic             adv, load;
  logic [NCH-1:0]   onehot;

  // Live-input clamp; only captured into the shadow on a load.
  always_comb begin
    eff_per = (period < CNT_W'(2)) ? CNT_W'(2) : period;
    if (high_cyc == '0)
      eff_hi = CNT_W'(1);
    else if (high_cyc > eff_per - CNT_W'(1))
      eff_hi = eff_per - CNT_W'(1);
    else
      eff_hi = high_cyc;
    eff_err = (period < CNT_W'(2)) || (eff_hi != high_cyc);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    per_d   = per_q;
    hi_d    = hi_q;
    err_d   = cfg_err;
    adv     = 1'b0;
    load    = 1'b0;
    case (state_q)
      S_IDLE: begin
        load = 1'b1;
        if (clk_en) begin
          state_d = S_RUN;
          cnt_d   = '0;
          ch_d    = '0;
          adv     = 1'b1;
        end
      end
      default: begin
        if (clk_en) begin
          state_d = S_RUN;
          adv     = 1'b1;
          if (cnt_q == per_q - CNT_W'(1)) begin
            cnt_d = '0;
            if (ch_q == C_LAST_CH) begin
              ch_d = '0;
              load = 1'b1;
            end else begin
              ch_d = ch_q + CH_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          state_d = S_HOLD;
        end
      end
    endcase
    if (load) begin
      per_d = eff_per;
      hi_d  = eff_hi;
      err_d = eff_err;
    end

    // Outputs are decoded from next-state values so they stay fully registered;
    // in HOLD cnt/ch/hi are unchanged, so clk_samp keeps its level.
    onehot = NCH'(1) << ch_d;
    samp_d = ((state_d != S_IDLE) && (cnt_d < hi_d)) ? onehot : '0;
    conv_d = (adv && (cnt_d == hi_d)) ? onehot : '0;
    fs_d   = adv && (cnt_d == '0) && (ch_d == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      ch_q       <= '0;
      per_q      <= CNT_W'(DEF_PERIOD);
      hi_q       <= CNT_W'(DEF_HIGH);
      cfg_err    <= 1'b0;
      clk_samp   <= '0;
      conv_start <= '0;
      frame_sync <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ch_q       <= ch_d;
      per_q      <= per_d;
      hi_q       <= hi_d;
      cfg_err    <= err_d;
      clk_samp   <= samp_d;
      conv_start <= conv_d;
      frame_sync <= fs_d;
    end
  end

endmodule
`default_nettype wire
